dsp_share_arbiter: RTL and testbench

//  Shares one DSP engine (add/mul/sub/FIR over 8x32-bit operand banks) among N_REQ requesters.

---
 rtl/dsp_share_arbiter_if.sv | 27 ++
 rtl/dsp_share_arbiter.sv | 150 +++++++++++++++
 tb/tb_dsp_share_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_share_arbiter_if.sv
// Request/response and DSP control bundle between the requesters, the shared DSP
// engine and dsp_share_arbiter. The arbiter connects through the slave modport.
interface dsp_share_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int SEL_W = 1
);
  logic [N_REQ-1:0]   req_valid;
  logic [2*N_REQ-1:0] req_op;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   resp_valid;
  logic               resp_err;
  logic [SEL_W-1:0]   gnt_sel;
  logic               busy;
  logic               dsp_start;
  logic [1:0]         dsp_op;
  logic               dsp_done;

  modport master (
    output req_valid, req_op, dsp_done,
    input  req_ready, resp_valid, resp_err, gnt_sel, busy, dsp_start, dsp_op
  );

  modport slave (
    input  req_valid, req_op, dsp_done,
    output req_ready, resp_valid, resp_err, gnt_sel, busy, dsp_start, dsp_op
  );
endinterface

// File: rtl/dsp_share_arbiter.sv
// Round-robin arbiter sharing one DSP engine among N_REQ requesters, with a
// watchdog that aborts an operation whose dsp_done never arrives.
module dsp_share_arbiter #(
  parameter int N_REQ   = 2,
  parameter int SEL_W   = 1,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  dsp_share_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1);
  localparam logic [15:0]      WDOG_LAST = 16'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0] gnt_sel_q, gnt_sel_d;
  logic [1:0]       dsp_op_q, dsp_op_d;
  logic [N_REQ-1:0] req_ready_q, req_ready_d;
  logic [N_REQ-1:0] resp_valid_q, resp_valid_d;
  logic             resp_err_q, resp_err_d;
  logic             busy_q, busy_d;
  logic             dsp_start_q, dsp_start_d;
  logic [15:0]      wdog_q, wdog_d;

  logic             found;
  logic             found_hi;
  logic [SEL_W-1:0] win_hi;
  logic [SEL_W-1:0] win_any;
  logic [SEL_W-1:0] winner;
  logic [1:0]       winner_op;

  // Lowest requester at or above rr_ptr wins; otherwise wrap to the lowest one overall.
  always_comb begin
    found    = 1'b0;
    found_hi = 1'b0;
    win_hi   = '0;
    win_any  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        found   = 1'b1;
        win_any = SEL_W'(i);
        if (i >= int'(rr_ptr_q)) begin
          found_hi = 1'b1;
          win_hi   = SEL_W'(i);
        end
      end
    end
    winner = found_hi ? win_hi : win_any;
  end

  always_comb begin
    winner_op = 2'b00;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == SEL_W'(i)) begin
        winner_op = bus.req_op[2*i +: 2];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_sel_d    = gnt_sel_q;
    dsp_op_d     = dsp_op_q;
    req_ready_d  = '0;
    resp_valid_d = '0;
    resp_err_d   = resp_err_q;
    busy_d       = busy_q;
    dsp_start_d  = 1'b0;
    wdog_d       = wdog_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_sel_d   = winner;
          dsp_op_d    = winner_op;
          req_ready_d = ONE_HOT0 << winner;
          busy_d      = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        dsp_start_d = 1'b1;
        wdog_d      = '0;
        state_d     = S_WAIT;
      end
      // A late dsp_done on the watchdog's last cycle still counts as a clean finish.
      S_WAIT: begin
        wdog_d = wdog_q + 16'd1;
        if (bus.dsp_done) begin
          resp_err_d   = 1'b0;
          resp_valid_d = ONE_HOT0 << gnt_sel_q;
          state_d      = S_RESP;
        end else if (wdog_q == WDOG_LAST) begin
          resp_err_d   = 1'b1;
          resp_valid_d = ONE_HOT0 << gnt_sel_q;
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        rr_ptr_d   = (gnt_sel_q == SEL_W'(N_REQ - 1)) ? '0 : gnt_sel_q + 1'b1;
        busy_d     = 1'b0;
        resp_err_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      gnt_sel_q    <= '0;
      dsp_op_q     <= 2'b00;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      dsp_start_q  <= 1'b0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_sel_q    <= gnt_sel_d;
      dsp_op_q     <= dsp_op_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      busy_q       <= busy_d;
      dsp_start_q  <= dsp_start_d;
      wdog_q       <= wdog_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.gnt_sel    = gnt_sel_q;
  assign bus.busy       = busy_q;
  assign bus.dsp_start  = dsp_start_q;
  assign bus.dsp_op     = dsp_op_q;

endmodule

// File: tb/tb_dsp_share_arbiter.sv
// Bench for dsp_share_arbiter: hand-written vectors, directed corner sequences and
// randomized transactions checked against a transaction-level reference model.
module tb_dsp_share_arbiter;

  localparam int N_REQ        = 2;
  localparam int SEL_W        = 1;
  localparam int OP_W         = 2 * N_REQ;
  localparam int TIMEOUT      = 10;
  localparam int LONG_TIMEOUT = 255;

  typedef struct {
    logic [N_REQ-1:0] mask;
    logic [OP_W-1:0]  ops;
    int               delay;
    bit               issueDone;
    int               expGnt;
    logic [1:0]       expOp;
    logic             expErr;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_REQ-1:0] reqValid = '0;
  logic [OP_W-1:0]  reqOp = '0;
  logic             dspDone = 1'b0;

  int checkCount = 0;
  int passCount  = 0;
  int modelPtr   = 0;

  vec_t vecs[9];

  dsp_share_arbiter_if #(.N_REQ(N_REQ), .SEL_W(SEL_W)) bus ();
  dsp_share_arbiter_if #(.N_REQ(N_REQ), .SEL_W(SEL_W)) longBus ();

  assign bus.req_valid     = reqValid;
  assign bus.req_op        = reqOp;
  assign bus.dsp_done      = dspDone;
  assign longBus.req_valid = reqValid;
  assign longBus.req_op    = reqOp;
  assign longBus.dsp_done  = dspDone;

  dsp_share_arbiter #(.N_REQ(N_REQ), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  dsp_share_arbiter #(.N_REQ(N_REQ), .SEL_W(SEL_W), .TIMEOUT(LONG_TIMEOUT)) longDut (
    .clk(clk),
    .rst(rst),
    .bus(longBus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] simulation time limit expired");
  end

  task automatic applyStimulus(input logic [N_REQ-1:0] v, input logic [OP_W-1:0] op, input logic done);
    reqValid = v;
    reqOp    = op;
    dspDone  = done;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // First valid requester searching upward from the pointer, wrapping around.
  function automatic int pickWinner(input logic [N_REQ-1:0] mask, input int ptr);
    for (int k = 0; k < N_REQ; k++) begin
      if (mask[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
    end
    return -1;
  endfunction

  task automatic doReset(input bit checkLong);
    rst = 1'b1;
    applyStimulus('0, '0, 1'b0);
    #1;
    checkOutput("reset.outs", 32'({bus.req_ready, bus.resp_valid, bus.resp_err, bus.busy,
                                   bus.dsp_start, bus.dsp_op, bus.gnt_sel}), 32'd0);
    if (checkLong)
      checkOutput("reset.longOuts", 32'({longBus.req_ready, longBus.resp_valid, longBus.busy,
                                         longBus.dsp_start, longBus.dsp_op}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one request from an IDLE negedge and follows it through to the IDLE cycle after RESP.
  task automatic doTransaction(input string name, input logic [N_REQ-1:0] mask, input logic [OP_W-1:0] ops,
                               input int delay, input bit issueDone, input int expGnt,
                               input logic [1:0] expOp, input logic expErr);
    logic [N_REQ-1:0] expOneHot;
    int latency;
    expOneHot = N_REQ'(1) << expGnt;
    latency   = (delay < TIMEOUT) ? delay + 1 : TIMEOUT;
    applyStimulus(mask, ops, 1'b0);
    @(negedge clk);
    checkOutput({name, ".ready"}, 32'(bus.req_ready), 32'(expOneHot));
    checkOutput({name, ".gnt"}, 32'(bus.gnt_sel), 32'(expGnt));
    checkOutput({name, ".opIssue"}, 32'(bus.dsp_op), 32'(expOp));
    checkOutput({name, ".busyNoStart"}, 32'({bus.busy, bus.dsp_start}), 32'(2'b10));
    applyStimulus(N_REQ'($urandom), OP_W'($urandom), issueDone);
    @(negedge clk);
    checkOutput({name, ".start"}, 32'({bus.dsp_start, bus.req_ready, bus.dsp_op}), 32'({1'b1, {N_REQ{1'b0}}, expOp}));
    for (int c = 0; c < latency; c++) begin
      applyStimulus(N_REQ'($urandom), OP_W'($urandom), c == delay);
      @(negedge clk);
      if (c == latency - 1) begin
        checkOutput({name, ".resp"}, 32'(bus.resp_valid), 32'(expOneHot));
        checkOutput({name, ".err"}, 32'(bus.resp_err), 32'(expErr));
        checkOutput({name, ".respGntOp"}, 32'({bus.busy, bus.dsp_start, bus.gnt_sel, bus.dsp_op}),
                    32'({1'b1, 1'b0, SEL_W'(expGnt), expOp}));
      end else begin
        checkOutput({name, ".wait"}, 32'({bus.resp_valid, bus.dsp_start, bus.busy, bus.dsp_op}),
                    32'({{N_REQ{1'b0}}, 1'b0, 1'b1, expOp}));
      end
    end
    applyStimulus(N_REQ'($urandom), OP_W'($urandom), 1'b0);
    @(negedge clk);
    checkOutput({name, ".idle"}, 32'({bus.busy, bus.resp_valid, bus.resp_err, bus.req_ready, bus.dsp_start}), 32'd0);
    applyStimulus('0, '0, 1'b0);
  endtask

  initial begin
    int starts;
    int resps;
    int doneIn;
    int order[4];
    logic [N_REQ-1:0] one;

    vecs[0] = '{mask: 2'b01, ops: 4'b0001, delay: 3,  issueDone: 1'b0, expGnt: 0, expOp: 2'b01, expErr: 1'b0};
    vecs[1] = '{mask: 2'b11, ops: 4'b1110, delay: 0,  issueDone: 1'b1, expGnt: 1, expOp: 2'b11, expErr: 1'b0};
    vecs[2] = '{mask: 2'b11, ops: 4'b0110, delay: 9,  issueDone: 1'b0, expGnt: 0, expOp: 2'b10, expErr: 1'b0};
    vecs[3] = '{mask: 2'b01, ops: 4'b1100, delay: 10, issueDone: 1'b0, expGnt: 0, expOp: 2'b00, expErr: 1'b1};
    vecs[4] = '{mask: 2'b10, ops: 4'b1000, delay: 12, issueDone: 1'b1, expGnt: 1, expOp: 2'b10, expErr: 1'b1};
    vecs[5] = '{mask: 2'b11, ops: 4'b0011, delay: 5,  issueDone: 1'b0, expGnt: 0, expOp: 2'b11, expErr: 1'b0};
    vecs[6] = '{mask: 2'b10, ops: 4'b0111, delay: 1,  issueDone: 1'b0, expGnt: 1, expOp: 2'b01, expErr: 1'b0};
    vecs[7] = '{mask: 2'b10, ops: 4'b1101, delay: 2,  issueDone: 1'b1, expGnt: 1, expOp: 2'b11, expErr: 1'b0};
    vecs[8] = '{mask: 2'b11, ops: 4'b0100, delay: 4,  issueDone: 1'b0, expGnt: 0, expOp: 2'b00, expErr: 1'b0};

    $display("[TB] reset and single op on the long-timeout instance");
    doReset(1'b1);
    applyStimulus(2'b01, 4'b0001, 1'b0);
    @(negedge clk);
    checkOutput("single.ready", 32'({longBus.req_ready, longBus.busy, longBus.dsp_start}), 32'({2'b01, 1'b1, 1'b0}));
    applyStimulus(2'b00, 4'b1110, 1'b0);
    @(negedge clk);
    checkOutput("single.start", 32'({longBus.dsp_start, longBus.dsp_op}), 32'({1'b1, 2'b01}));
    for (int c = 0; c <= 20; c++) begin
      applyStimulus(2'b00, 4'b1110, c == 20);
      @(negedge clk);
      if (c == 20) begin
        checkOutput("single.resp", 32'({longBus.resp_valid, longBus.resp_err, longBus.dsp_op, longBus.busy}),
                    32'({2'b01, 1'b0, 2'b01, 1'b1}));
      end else begin
        checkOutput("single.wait", 32'({longBus.resp_valid, longBus.dsp_start, longBus.dsp_op, longBus.busy}),
                    32'({2'b00, 1'b0, 2'b01, 1'b1}));
      end
    end
    applyStimulus('0, '0, 1'b0);
    @(negedge clk);
    checkOutput("single.idle", 32'({longBus.busy, longBus.resp_valid}), 32'd0);

    $display("[TB] table vectors");
    doReset(1'b0);
    for (int i = 0; i < 9; i++) begin
      doTransaction($sformatf("vec%0d", i), vecs[i].mask, vecs[i].ops, vecs[i].delay,
                    vecs[i].issueDone, vecs[i].expGnt, vecs[i].expOp, vecs[i].expErr);
    end

    $display("[TB] stale done after timeout");
    doTransaction("stale.timeout", 2'b01, 4'b0011, 40, 1'b0, 0, 2'b11, 1'b1);
    applyStimulus('0, '0, 1'b1);
    @(negedge clk);
    checkOutput("stale.idle", 32'({bus.busy, bus.req_ready, bus.resp_valid}), 32'd0);
    applyStimulus('0, '0, 1'b0);
    doTransaction("stale.next", 2'b10, 4'b1000, 4, 1'b1, 1, 2'b10, 1'b0);

    $display("[TB] contention");
    doReset(1'b0);
    order = '{0, 1, 0, 1};
    one = N_REQ'(1);
    starts = 0;
    resps = 0;
    doneIn = -1;
    applyStimulus(2'b11, 4'b0110, 1'b0);
    for (int cyc = 0; cyc < 200 && resps < 4; cyc++) begin
      @(negedge clk);
      if (bus.dsp_start) begin
        starts++;
        doneIn = 2;
      end
      if (bus.resp_valid != '0) begin
        checkOutput($sformatf("cont.resp%0d", resps), 32'(bus.resp_valid), 32'(one << order[resps]));
        checkOutput($sformatf("cont.gnt%0d", resps), 32'({bus.gnt_sel, bus.resp_err}), 32'({SEL_W'(order[resps]), 1'b0}));
        resps++;
      end
      applyStimulus((resps < 4) ? 2'b11 : 2'b00, 4'b0110, doneIn == 0);
      if (doneIn >= 0) doneIn--;
    end
    applyStimulus('0, '0, 1'b0);
    repeat (4) begin
      @(negedge clk);
      if (bus.dsp_start) starts++;
    end
    checkOutput("cont.respCount", 32'(resps), 32'd4);
    checkOutput("cont.startCount", 32'(starts), 32'd4);

    $display("[TB] reset mid-WAIT");
    doReset(1'b0);
    doTransaction("rstPre", 2'b01, 4'b0010, 1, 1'b0, 0, 2'b10, 1'b0);
    applyStimulus(2'b10, 4'b1100, 1'b0);
    @(negedge clk);
    checkOutput("rstMid.ready", 32'(bus.req_ready), 32'(2'b10));
    applyStimulus('0, '0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("rstMid.inWait", 32'({bus.busy, bus.resp_valid}), 32'({1'b1, 2'b00}));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rstMid.async", 32'({bus.req_ready, bus.resp_valid, bus.resp_err, bus.busy,
                                     bus.dsp_start, bus.dsp_op, bus.gnt_sel}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstMid.noResp", 32'({bus.busy, bus.resp_valid, bus.resp_err}), 32'd0);
    doTransaction("rstPost", 2'b11, 4'b0111, 2, 1'b0, 0, 2'b11, 1'b0);

    $display("[TB] randomized transactions");
    doReset(1'b0);
    modelPtr = 0;
    for (int t = 0; t < 40; t++) begin
      logic [N_REQ-1:0] mask;
      logic [OP_W-1:0] ops;
      int delay;
      int w;
      int gaps;
      mask  = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      ops   = OP_W'($urandom);
      delay = $urandom_range(0, TIMEOUT + 3);
      w     = pickWinner(mask, modelPtr);
      doTransaction($sformatf("rand%0d", t), mask, ops, delay, 1'($urandom), w,
                    2'(ops >> (2 * w)), delay >= TIMEOUT);
      modelPtr = (w + 1) % N_REQ;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        applyStimulus('0, OP_W'($urandom), 1'($urandom));
        @(negedge clk);
        checkOutput($sformatf("rand%0d.gap", t), 32'({bus.busy, bus.req_ready, bus.resp_valid}), 32'd0);
      end
      applyStimulus('0, '0, 1'b0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
